// File: rtl/core_timer.sv
`default_nettype none
// ============================================================================
// Module      : core_timer
// Description : Machine timer with a prescaled 64-bit mtime counter, a 64-bit
//               mtimecmp compare register, a control register (bit 0 = en)
//               and a single-outstanding request/response register port.
//               time_irq_o is asserted whenever mtime >= mtimecmp.
// Ports       : clk_i          - clock for all state
//               rstn_i         - synchronous active-low reset
//               req_valid_i    - register request valid
//               req_ready_o    - register request ready (high in IDLE)
//               req_we_i       - 1 = write, 0 = read
//               req_addr_i     - byte address: 0x00 mtime, 0x08 mtimecmp,
//                                0x10 ctrl
//               req_wdata_i    - write data
//               req_wstrb_i    - write byte enables
//               resp_valid_o   - response valid (high in RESP)
//               resp_ready_i   - response accepted
//               resp_rdata_o   - read data (0 for writes and errors)
//               resp_err_o     - bad-address error
//               time_o         - current mtime
//               time_irq_o     - timer interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module core_timer #(
    parameter int unsigned PRESCALE_DIV = 10
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [4:0]  req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wstrb_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [63:0] time_o,
    output logic        time_irq_o
);

    localparam logic [15:0] c_PRESCALE_MAX = 16'(PRESCALE_DIV - 1);

    localparam logic [0:0]  c_ST_IDLE = 1'b0;
    localparam logic [0:0]  c_ST_RESP = 1'b1;

    localparam logic [4:0]  c_ADDR_MTIME    = 5'h00;
    localparam logic [4:0]  c_ADDR_MTIMECMP = 5'h08;
    localparam logic [4:0]  c_ADDR_CTRL     = 5'h10;

    localparam logic [63:0] c_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [0:0]  r_state;
    logic [15:0] r_prescaler;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_tick;
    logic        w_sel_mtime;
    logic        w_sel_mtimecmp;
    logic        w_sel_ctrl;
    logic        w_bad_addr;
    logic        w_wr_ok;
    logic [63:0] w_wmask;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_next;
    logic [15:0] w_prescaler_next;
    logic [63:0] w_rdata_next;

    // Expand byte strobes into a bit mask.
    for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
        assign w_wmask[gi*8 +: 8] = {8{req_wstrb_i[gi]}};
    end

    assign w_accept       = (r_state == c_ST_IDLE) && req_valid_i;
    assign w_tick         = r_en && (r_prescaler == c_PRESCALE_MAX);

    // Only the three 8-byte aligned register offsets decode; anything else
    // (including misaligned offsets) is an error.
    assign w_sel_mtime    = (req_addr_i == c_ADDR_MTIME);
    assign w_sel_mtimecmp = (req_addr_i == c_ADDR_MTIMECMP);
    assign w_sel_ctrl     = (req_addr_i == c_ADDR_CTRL);
    assign w_bad_addr     = !(w_sel_mtime || w_sel_mtimecmp || w_sel_ctrl);
    assign w_wr_ok        = w_accept && req_we_i && !w_bad_addr;

    // Strobed bytes of an mtime write override the incremented value, so a
    // write landing on a tick edge wins over the increment.
    assign w_mtime_inc    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    assign w_mtime_next   = (w_wr_ok && w_sel_mtime)
                          ? ((w_mtime_inc & ~w_wmask) | (req_wdata_i & w_wmask))
                          : w_mtime_inc;

    always_comb begin
        w_prescaler_next = r_prescaler;
        if (w_tick) begin
            w_prescaler_next = 16'd0;
        end else if (r_en) begin
            w_prescaler_next = r_prescaler + 16'd1;
        end
    end

    // Read data is sampled from register values before the acceptance edge.
    always_comb begin
        w_rdata_next = 64'd0;
        if (!req_we_i) begin
            if (w_sel_mtime) begin
                w_rdata_next = r_mtime;
            end else if (w_sel_mtimecmp) begin
                w_rdata_next = r_mtimecmp;
            end else if (w_sel_ctrl) begin
                w_rdata_next = {63'd0, r_en};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_prescaler <= 16'd0;
            r_mtime     <= 64'd0;
            r_mtimecmp  <= c_CMP_RESET;
            r_en        <= 1'b1;
        end else begin
            r_prescaler <= w_prescaler_next;
            r_mtime     <= w_mtime_next;
            if (w_wr_ok && w_sel_mtimecmp) begin
                r_mtimecmp <= (r_mtimecmp & ~w_wmask) | (req_wdata_i & w_wmask);
            end
            if (w_wr_ok && w_sel_ctrl && req_wstrb_i[0]) begin
                r_en <= req_wdata_i[0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= c_ST_IDLE;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid_i) begin
                        r_state <= c_ST_RESP;
                        r_rdata <= w_rdata_next;
                        r_err   <= w_bad_addr;
                    end
                end
                c_ST_RESP: begin
                    if (resp_ready_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so it is low for every cycle reset is held.
    assign req_ready_o  = rstn_i && (r_state == c_ST_IDLE);
    assign resp_valid_o = (r_state == c_ST_RESP);
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;
    assign time_o       = r_mtime;
    assign time_irq_o   = (r_mtime >= r_mtimecmp);

endmodule
`default_nettype wire

// File: tb/tb_core_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_timer
// Description : Self-checking bench for core_timer. A reference model keeps
//               mtime as (base + enabled_cycles / DIV) and tracks mtimecmp,
//               en and the single outstanding response; scenario tasks
//               compare DUT outputs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_timer;

    localparam int unsigned DIV = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] time_v;
    logic        time_irq;

    int n_checks = 0;
    int n_pass   = 0;

    core_timer #(.PRESCALE_DIV(DIV)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .time_o       (time_v),
        .time_irq_o   (time_irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [63:0]     m_base;
    longint unsigned m_cnt;
    logic [63:0]     m_cmp;
    logic            m_en;
    logic            m_busy;
    logic [63:0]     m_exp_rdata;
    logic            m_exp_err;
    logic            m_acc;
    logic            m_bad;
    logic [63:0]     m_mask;
    logic [63:0]     m_cur;

    function automatic logic [63:0] model_time();
        return m_base + 64'(m_cnt / DIV);
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_base = 64'd0; m_cnt = 0; m_cmp = '1; m_en = 1'b1;
            m_busy = 1'b0; m_exp_rdata = 64'd0; m_exp_err = 1'b0;
        end else begin
            m_acc = !m_busy && req_valid;
            if (m_busy && resp_ready) m_busy = 1'b0;
            m_bad = !(req_addr == 5'h00 || req_addr == 5'h08 || req_addr == 5'h10);
            if (m_acc) begin
                m_exp_err   = m_bad;
                m_exp_rdata = 64'd0;
                if (!req_we && !m_bad) begin
                    if (req_addr == 5'h00)      m_exp_rdata = model_time();
                    else if (req_addr == 5'h08) m_exp_rdata = m_cmp;
                    else                        m_exp_rdata = {63'd0, m_en};
                end
                m_busy = 1'b1;
            end
            if (m_en) m_cnt = m_cnt + 1;
            if (m_acc && req_we && !m_bad) begin
                for (int i = 0; i < 8; i++) m_mask[i*8 +: 8] = {8{req_wstrb[i]}};
                if (req_addr == 5'h00) begin
                    m_cur  = model_time();
                    m_base = (m_cur & ~m_mask) | (req_wdata & m_mask);
                    m_cnt  = m_cnt % DIV;   // keep prescaler phase
                end else if (req_addr == 5'h08) begin
                    m_cmp = (m_cmp & ~m_mask) | (req_wdata & m_mask);
                end else if (req_wstrb[0]) begin
                    m_en = req_wdata[0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus driver: call at a negedge with the DUT idle. Returns values seen
    // at the negedge after the acceptance edge, and returns one negedge
    // after the response handshake edge.
    // ------------------------------------------------------------------
    task automatic bus(input logic w, input logic [4:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd, output logic er,
                       output logic vld, output logic [63:0] t1, output logic irq1);
        req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_wstrb = s;
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rd = resp_rdata; er = resp_err; vld = resp_valid; t1 = time_v; irq1 = time_irq;
        req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    // Wait at negedges until the next posedge is a tick edge.
    task automatic align_tick();
        for (int i = 0; i < 3 * DIV && (m_cnt % DIV) != DIV - 1; i++) @(negedge clk);
    endtask

    logic [63:0] rd, t1;
    logic        er, vld, irq1;

    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'd0;
        req_wdata = 64'd0; req_wstrb = 8'd0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else n_pass++;
        n_checks++; if (time_v !== 64'd0) $display("FAIL reset_time got=%h exp=0", time_v); else n_pass++;
        n_checks++; if (time_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", time_irq); else n_pass++;
        n_checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0)
            $display("FAIL reset_resp got=%h/%b exp=0/0", resp_rdata, resp_err); else n_pass++;
        rstn = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready got=%b exp=1", req_ready); else n_pass++;
    endtask

    task automatic test_count();
        repeat (100) @(posedge clk);
        @(negedge clk);
        n_checks++; if (time_v !== 64'd10) $display("FAIL count_100 got=%0d exp=10", time_v); else n_pass++;
        n_checks++; if (time_irq !== 1'b0) $display("FAIL count_irq got=%b exp=0", time_irq); else n_pass++;
    endtask

    task automatic test_cmp_irq();
        logic early;
        logic found;
        early = 1'b0; found = 1'b0;
        bus(1'b1, 5'h00, 64'd0, 8'hFF, rd, er, vld, t1, irq1);
        bus(1'b1, 5'h08, 64'd5, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 64'd0)
            $display("FAIL cmp_write_resp got=%b/%b/%h exp=1/0/0", vld, er, rd); else n_pass++;
        for (int i = 0; i < 200; i++) begin
            if (time_v == 64'd5) begin found = 1'b1; break; end
            if (time_irq !== 1'b0) early = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        n_checks++; if (!found || early) $display("FAIL irq_reach5 got=found%b/early%b exp=1/0", found, early); else n_pass++;
        n_checks++; if (time_irq !== 1'b1) $display("FAIL irq_at5 got=%b exp=1", time_irq); else n_pass++;
        bus(1'b1, 5'h08, '1, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (irq1 !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq1); else n_pass++;
    endtask

    task automatic test_wrap();
        align_tick();
        bus(1'b1, 5'h00, '1, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (t1 !== '1 || er !== 1'b0) $display("FAIL wrap_write got=%h/%b exp=all-ones/0", t1, er); else n_pass++;
        repeat (9) @(posedge clk);
        @(negedge clk);
        n_checks++; if (time_v !== 64'd0) $display("FAIL wrap_zero got=%h exp=0", time_v); else n_pass++;
        n_checks++; if (resp_err !== 1'b0 || time_irq !== 1'b0)
            $display("FAIL wrap_flags got=%b/%b exp=0/0", resp_err, time_irq); else n_pass++;
    endtask

    task automatic test_tick_write();
        int edges;
        edges = 0;
        align_tick();
        bus(1'b1, 5'h00, 64'h1234, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (t1 !== 64'h1234) $display("FAIL tickwr_value got=%h exp=1234", t1); else n_pass++;
        for (int k = 2; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (time_v != 64'h1234) begin edges = k; break; end
        end
        n_checks++; if (edges != DIV) $display("FAIL tickwr_interval got=%0d exp=%0d", edges, DIV); else n_pass++;
        n_checks++; if (time_v !== 64'h1235) $display("FAIL tickwr_next got=%h exp=1235", time_v); else n_pass++;
    endtask

    task automatic test_errors();
        logic [63:0] cmp_before;
        logic [63:0] exp_t;
        bus(1'b1, 5'h08, 64'h0000_0000_0000_9000, 8'hFF, rd, er, vld, t1, irq1);
        cmp_before = m_cmp;
        bus(1'b0, 5'h04, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL err_read04 got=%b/%h exp=1/0", er, rd); else n_pass++;
        bus(1'b1, 5'h18, 64'hDEAD_BEEF_0000_0000, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL err_write18 got=%b/%h exp=1/0", er, rd); else n_pass++;
        bus(1'b1, 5'h09, 64'd0, 8'hFF, rd, er, vld, t1, irq1);
        n_checks++; if (er !== 1'b1) $display("FAIL err_write09 got=%b exp=1", er); else n_pass++;
        bus(1'b0, 5'h08, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (rd !== 64'h9000 || cmp_before !== 64'h9000 || er !== 1'b0)
            $display("FAIL err_cmp_unchanged got=%h exp=9000", rd); else n_pass++;
        exp_t = model_time();
        n_checks++; if (time_v !== exp_t) $display("FAIL err_time got=%h exp=%h", time_v, exp_t); else n_pass++;
    endtask

    task automatic test_ctrl();
        logic [63:0] t_hold;
        bus(1'b1, 5'h10, 64'hFFFF_0000_1234_5676, 8'hFF, rd, er, vld, t1, irq1);
        bus(1'b0, 5'h10, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (rd !== 64'd0) $display("FAIL ctrl_read_dis got=%h exp=0", rd); else n_pass++;
        t_hold = time_v;
        repeat (35) @(negedge clk);
        n_checks++; if (time_v !== t_hold) $display("FAIL ctrl_hold got=%h exp=%h", time_v, t_hold); else n_pass++;
        bus(1'b1, 5'h10, 64'h1, 8'h00, rd, er, vld, t1, irq1);
        bus(1'b0, 5'h10, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (rd !== 64'd0 || er !== 1'b0) $display("FAIL ctrl_zero_strobe got=%h exp=0", rd); else n_pass++;
        bus(1'b1, 5'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, rd, er, vld, t1, irq1);
        bus(1'b0, 5'h10, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (rd !== 64'd1) $display("FAIL ctrl_read_en got=%h exp=1", rd); else n_pass++;
    endtask

    task automatic test_stall();
        logic [63:0] first;
        logic        stable;
        stable = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h00; resp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        first = resp_rdata;
        n_checks++; if (first !== m_exp_rdata) $display("FAIL stall_rdata got=%h exp=%h", first, m_exp_rdata); else n_pass++;
        req_addr = 5'h08; req_we = 1'b1; req_wdata = 64'd0; req_wstrb = 8'hFF;   // must be ignored
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        n_checks++; if (!stable) $display("FAIL stall_stable got=0 exp=1"); else n_pass++;
        n_checks++; if (m_cmp !== 64'h9000) $display("FAIL stall_ignore_cmp got=%h exp=9000", m_cmp); else n_pass++;
        req_valid = 1'b0; req_we = 1'b0;
        rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL stall_reset got=%b/%b exp=0/0", resp_valid, req_ready); else n_pass++;
        @(posedge clk); @(negedge clk);
        rstn = 1'b1; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0 || time_v !== 64'd0)
            $display("FAIL stall_after_reset got=%b/%h exp=0/0", resp_valid, time_v); else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [63:0] d;
        logic [7:0]  s;
        logic        w;
        int          bad;
        logic [63:0] exp_t;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            case ($urandom_range(0, 5))
                0: a = 5'h00;
                1, 2: a = 5'h08;
                3: a = 5'h10;
                4: a = 5'($urandom);
                default: a = 5'h08;
            endcase
            w = 1'($urandom);
            d = {32'($urandom), 32'($urandom)};
            if (a == 5'h08 && $urandom_range(0, 1) == 1) d = model_time() + 64'($urandom_range(0, 20));
            if (a == 5'h00 && $urandom_range(0, 1) == 1) d = {48'd0, 16'($urandom)};
            if (a == 5'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 1) == 1) s = 8'hFF;
            if (req_ready !== 1'b1) bad++;
            bus(w, a, d, s, rd, er, vld, t1, irq1);
            if (vld !== 1'b1 || rd !== m_exp_rdata || er !== m_exp_err) begin
                bad++;
                $display("FAIL rand_resp n=%0d got=%b/%h/%b exp=1/%h/%b", n, vld, rd, er, m_exp_rdata, m_exp_err);
            end
            exp_t = model_time();
            if (time_v !== exp_t || time_irq !== (exp_t >= m_cmp)) begin
                bad++;
                $display("FAIL rand_time n=%0d got=%h/%b exp=%h/%b", n, time_v, time_irq, exp_t, exp_t >= m_cmp);
            end
        end
        n_checks++; if (bad != 0) $display("FAIL rand_summary got=%0d errors exp=0", bad); else n_pass++;
        bus(1'b0, 5'h08, 64'd0, 8'h00, rd, er, vld, t1, irq1);
        n_checks++; if (rd !== m_cmp) $display("FAIL rand_cmp_readback got=%h exp=%h", rd, m_cmp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_count();
        test_cmp_irq();
        test_wrap();
        test_tick_write();
        test_errors();
        test_ctrl();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
